// File: rtl/bspline_coeff_updater_pkg.sv
// Shared types and constants for the cubic B-spline coefficient updater.
// Holds the FSM encoding, Q16 constants and the coefficient saturation helper.
package bspline_coeff_updater_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SEG   = 3'd1,
        POW   = 3'd2,
        BASIS = 3'd3,
        UPD   = 3'd4,
        DONE  = 3'd5
    } state_t;

    localparam int INV6    = 10923;
    localparam int ONE_Q16 = 65536;

    // Clamp a wide signed value into a w-bit two's complement range.
    function automatic logic signed [63:0] saturate(
        input logic signed [63:0] v,
        input int                 w
    );
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
    endfunction

endpackage

// File: rtl/bspline_coeff_updater_basis.sv
// Three-stage cubic uniform B-spline basis datapath: segment split,
// powers of t and (1-t), then the four scaled basis weights.
module bspline_basis_cubic
    import bspline_coeff_updater_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int GRID_SIZE  = 8,
    parameter int IW         = $clog2(GRID_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  seg_en,
    input  logic                  pow_en,
    input  logic                  basis_en,
    input  logic [DATA_WIDTH-1:0] x,
    output logic [IW-1:0]         seg,
    output logic [16:0]           b0,
    output logic [16:0]           b1,
    output logic [16:0]           b2,
    output logic [16:0]           b3
);

    localparam int NSEG = GRID_SIZE - 3;

    logic [31:0] xq;
    logic [31:0] p;
    logic [15:0] t_s;
    logic [15:0] t_p;
    logic [15:0] t2_p;
    logic [15:0] t3_p;
    logic [16:0] u3_p;
    logic [15:0] t2_n;
    logic [15:0] t3_n;
    logic [16:0] u;
    logic [16:0] u2_n;
    logic [16:0] u3_n;
    logic signed [31:0] t_i;
    logic signed [31:0] t2_i;
    logic signed [31:0] t3_i;
    logic signed [31:0] n1;
    logic signed [31:0] n2;

    function automatic logic [16:0] scale(input logic [31:0] n);
        return 17'((48'(n) * 48'(INV6)) >> 16);
    endfunction

    // Sample is renormalised to Q0.16 before the segment split.
    assign xq = (32'(x) << 16) >> DATA_WIDTH;
    assign p  = xq * 32'(NSEG);

    assign t2_n = 16'((32'(t_s) * 32'(t_s)) >> 16);
    assign t3_n = 16'((32'(t2_n) * 32'(t_s)) >> 16);
    assign u    = 17'(ONE_Q16) - 17'(t_s);
    assign u2_n = 17'((34'(u) * 34'(u)) >> 16);
    assign u3_n = 17'((34'(u2_n) * 34'(u)) >> 16);

    assign t_i  = 32'(t_p);
    assign t2_i = 32'(t2_p);
    assign t3_i = 32'(t3_p);
    assign n1   = 32'sd3 * t3_i - 32'sd6 * t2_i + 32'sd262144;
    assign n2   = -32'sd3 * t3_i + 32'sd3 * t2_i + 32'sd3 * t_i + 32'sd65536;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg  <= '0;
            t_s  <= '0;
            t_p  <= '0;
            t2_p <= '0;
            t3_p <= '0;
            u3_p <= '0;
            b0   <= '0;
            b1   <= '0;
            b2   <= '0;
            b3   <= '0;
        end else begin
            if (seg_en) begin
                seg <= IW'(p >> 16);
                t_s <= 16'(p);
            end
            if (pow_en) begin
                t_p  <= t_s;
                t2_p <= t2_n;
                t3_p <= t3_n;
                u3_p <= u3_n;
            end
            if (basis_en) begin
                b0 <= scale(32'(u3_p));
                b1 <= scale(n1);
                b2 <= scale(n2);
                b3 <= scale(32'(t3_p));
            end
        end
    end

endmodule

// File: rtl/bspline_coeff_updater.sv
// Online gradient update of cubic B-spline coefficients held in flops,
// with a direct load port that has priority while idle.
module bspline_coeff_updater
    import bspline_coeff_updater_pkg::*;
#(
    parameter int DATA_WIDTH  = 16,
    parameter int COEFF_WIDTH = 16,
    parameter int GRID_SIZE   = 8
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic [DATA_WIDTH-1:0]            x_in,
    input  logic [COEFF_WIDTH-1:0]           err_in,
    input  logic [3:0]                       lr_shift,
    input  logic                             load_en,
    input  logic [$clog2(GRID_SIZE)-1:0]     load_idx,
    input  logic [COEFF_WIDTH-1:0]           load_data,
    output logic                             load_drop,
    output logic [GRID_SIZE*COEFF_WIDTH-1:0] coeff_out,
    output logic                             upd_done
);

    localparam int CW = COEFF_WIDTH;
    localparam int IW = $clog2(GRID_SIZE);

    state_t                state;
    logic [DATA_WIDTH-1:0] x_r;
    logic signed [CW-1:0]  err_r;
    logic [3:0]            lr_r;
    logic [1:0]            j;
    logic signed [CW-1:0]  coeff [GRID_SIZE];

    logic [IW-1:0]         seg;
    logic [16:0]           b0;
    logic [16:0]           b1;
    logic [16:0]           b2;
    logic [16:0]           b3;
    logic [16:0]           b_sel;
    logic [IW-1:0]         idx;
    logic signed [17:0]    b_ext;
    logic signed [CW+17:0] prod;
    logic signed [CW+17:0] delta;
    logic [5:0]            sh;
    logic signed [63:0]    diff;
    logic signed [CW-1:0]  new_c;
    logic                  accept;

    bspline_basis_cubic #(
        .DATA_WIDTH (DATA_WIDTH),
        .GRID_SIZE  (GRID_SIZE),
        .IW         (IW)
    ) u_basis (
        .clk      (clk),
        .rst      (rst),
        .seg_en   (state == SEG),
        .pow_en   (state == POW),
        .basis_en (state == BASIS),
        .x        (x_r),
        .seg      (seg),
        .b0       (b0),
        .b1       (b1),
        .b2       (b2),
        .b3       (b3)
    );

    assign in_ready = (state == IDLE) && !load_en;
    assign accept   = in_valid && in_ready;
    assign upd_done = (state == DONE);

    always_comb begin
        b_sel = b0;
        unique case (j)
            2'd0: b_sel = b0;
            2'd1: b_sel = b1;
            2'd2: b_sel = b2;
            2'd3: b_sel = b3;
        endcase
    end

    // Floor-shifted gradient step, subtracted then clamped to the coeff range.
    assign idx   = seg + IW'(j);
    assign b_ext = {1'b0, b_sel};
    assign prod  = (CW+18)'(err_r) * (CW+18)'(b_ext);
    assign sh    = 6'd16 + 6'(lr_r);
    assign delta = prod >>> sh;
    assign diff  = 64'(coeff[idx]) - 64'(delta);
    assign new_c = CW'(saturate(diff, CW));

    for (genvar k = 0; k < GRID_SIZE; k++) begin : g_out
        assign coeff_out[k*CW +: CW] = coeff[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            x_r       <= '0;
            err_r     <= '0;
            lr_r      <= '0;
            j         <= '0;
            load_drop <= 1'b0;
            for (int k = 0; k < GRID_SIZE; k++)
                coeff[k] <= '0;
        end else begin
            load_drop <= load_en && (state != IDLE);
            unique case (state)
                IDLE: begin
                    if (load_en) begin
                        if (32'(load_idx) < GRID_SIZE)
                            coeff[load_idx] <= load_data;
                    end else if (accept) begin
                        x_r   <= x_in;
                        err_r <= err_in;
                        lr_r  <= lr_shift;
                        state <= SEG;
                    end
                end
                SEG:   state <= POW;
                POW:   state <= BASIS;
                BASIS: begin
                    j     <= 2'd0;
                    state <= UPD;
                end
                UPD: begin
                    coeff[idx] <= new_c;
                    j          <= j + 2'd1;
                    if (j == 2'd3)
                        state <= DONE;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_bspline_coeff_updater.sv
// Randomized bench for bspline_coeff_updater against an integer reference
// model of the cubic B-spline gradient update.
module tb_bspline_coeff_updater;

    localparam int DW = 16;
    localparam int CW = 16;
    localparam int GS = 8;
    localparam int IW = $clog2(GS);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [DW-1:0]     x_in = '0;
    logic [CW-1:0]     err_in = '0;
    logic [3:0]        lr_shift = '0;
    logic              load_en = 1'b0;
    logic [IW-1:0]     load_idx = '0;
    logic [CW-1:0]     load_data = '0;
    logic              load_drop;
    logic [GS*CW-1:0]  coeff_out;
    logic              upd_done;

    longint mdl [GS];
    int     n_vec = 0;
    int     n_bad = 0;

    bspline_coeff_updater #(
        .DATA_WIDTH  (DW),
        .COEFF_WIDTH (CW),
        .GRID_SIZE   (GS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .x_in      (x_in),
        .err_in    (err_in),
        .lr_shift  (lr_shift),
        .load_en   (load_en),
        .load_idx  (load_idx),
        .load_data (load_data),
        .load_drop (load_drop),
        .coeff_out (coeff_out),
        .upd_done  (upd_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input longint got, input longint exp);
        n_vec++;
        if (got != exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic longint c_dut(input int k);
        logic signed [CW-1:0] v;
        v = coeff_out[k*CW +: CW];
        return longint'(v);
    endfunction

    function automatic longint floor_div(input longint a, input longint m);
        longint q;
        q = a / m;
        if ((a % m != 0) && (a < 0))
            q = q - 1;
        return q;
    endfunction

    // Reference: evaluate the four cubic basis weights and apply the step.
    function automatic void ref_update(input longint x, input longint err, input int lr);
        longint p, s, t, t2, t3, u, u3, b, d, v, hi, lo;
        longint n [4];
        p  = x * (GS - 3);
        s  = p / 65536;
        t  = p % 65536;
        t2 = (t * t) / 65536;
        t3 = (t2 * t) / 65536;
        u  = 65536 - t;
        u3 = (((u * u) / 65536) * u) / 65536;
        n[0] = u3;
        n[1] = 3 * t3 - 6 * t2 + 4 * 65536;
        n[2] = -3 * t3 + 3 * t2 + 3 * t + 65536;
        n[3] = t3;
        hi = (longint'(1) << (CW - 1)) - 1;
        lo = -hi - 1;
        for (int jj = 0; jj < 4; jj++) begin
            b = (n[jj] * 10923) / 65536;
            d = floor_div(err * b, longint'(1) << (16 + lr));
            v = mdl[s + jj] - d;
            if (v > hi) v = hi;
            if (v < lo) v = lo;
            mdl[s + jj] = v;
        end
    endfunction

    task automatic check_all(input string tag);
        for (int k = 0; k < GS; k++)
            chk($sformatf("%s_c%0d", tag, k), c_dut(k), mdl[k]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < GS; k++)
            mdl[k] = 0;
    endtask

    task automatic do_load(input int idx, input longint data, input bit with_valid, input string tag);
        int hits;
        @(negedge clk);
        load_en   = 1'b1;
        load_idx  = IW'(idx);
        load_data = CW'(data);
        in_valid  = with_valid;
        #1 chk({tag, "_rdy_low"}, longint'(in_ready), 0);
        @(negedge clk);
        load_en  = 1'b0;
        in_valid = 1'b0;
        if (idx < GS)
            mdl[idx] = data;
        if (with_valid) begin
            hits = 0;
            repeat (10) begin
                @(negedge clk);
                if (upd_done) hits++;
            end
            chk({tag, "_no_upd"}, hits, 0);
        end
        check_all(tag);
    endtask

    // inject > 0 pulses a load request on that cycle of the update.
    task automatic do_update(input longint x, input longint err, input int lr,
                             input int inject, input string tag);
        int done_at;
        @(negedge clk);
        x_in     = DW'(x);
        err_in   = CW'(err);
        lr_shift = 4'(lr);
        in_valid = 1'b1;
        #1 chk({tag, "_rdy"}, longint'(in_ready), 1);
        @(negedge clk);
        in_valid = 1'b0;
        done_at  = 0;
        for (int k = 1; k <= 20 && done_at == 0; k++) begin
            if (k > 1) @(negedge clk);
            if (k == inject) begin
                load_en   = 1'b1;
                load_idx  = IW'(k);
                load_data = 16'h1234;
            end
            if (inject > 0 && k == inject + 1) begin
                chk({tag, "_drop"}, longint'(load_drop), 1);
                load_en = 1'b0;
            end
            if (upd_done) done_at = k;
        end
        chk({tag, "_lat"}, done_at, 8);
        ref_update(x, err, lr);
        @(negedge clk);
        chk({tag, "_done_pulse"}, longint'(upd_done), 0);
        check_all(tag);
    endtask

    task automatic reset_mid_update();
        int hits;
        @(negedge clk);
        x_in     = 16'h4000;
        err_in   = 16'd3000;
        lr_shift = 4'd0;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        for (int k = 0; k < GS; k++)
            mdl[k] = 0;
        check_all("rst_mid");
        chk("rst_mid_done", longint'(upd_done), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        hits = 0;
        repeat (12) begin
            @(negedge clk);
            if (upd_done) hits++;
        end
        chk("rst_mid_no_done", hits, 0);
        chk("rst_mid_rdy", longint'(in_ready), 1);
        check_all("rst_mid_after");
    endtask

    initial begin
        #2000000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int op;
        do_reset();
        #1;
        chk("rst_rdy", longint'(in_ready), 1);
        chk("rst_done", longint'(upd_done), 0);
        chk("rst_drop", longint'(load_drop), 0);
        check_all("rst");

        do_update(0, 6144, 0, 0, "basic");
        chk("basic_c0_abs", c_dut(0), -1024);
        chk("basic_c1_abs", c_dut(1), -4096);
        chk("basic_c2_abs", c_dut(2), -1024);

        do_reset();
        do_update(0, 6144, 2, 0, "lr2");
        chk("lr2_c1_abs", c_dut(1), -1024);

        do_reset();
        do_load(0, -32700, 1'b0, "ld0");
        do_update(0, 6144, 0, 0, "sat");
        chk("sat_c0_abs", c_dut(0), -32768);

        do_reset();
        do_load(2, 777, 1'b0, "ld2");
        do_update(65535, -6144, 0, 0, "top");
        chk("top_c2_keep", c_dut(2), 777);

        do_update(1234, 500, 1, 5, "inj");
        do_load(3, -5, 1'b1, "ldv");

        reset_mid_update();
        do_update(30000, -2000, 3, 0, "after_rst");

        for (int i = 0; i < 60; i++) begin
            op = int'($urandom_range(0, 3));
            if (op == 0)
                do_load(int'($urandom_range(0, GS - 1)),
                        longint'($signed(16'($urandom))), 1'b0, "rld");
            else
                do_update(longint'($urandom_range(0, 65535)),
                          longint'($signed(16'($urandom))),
                          int'($urandom_range(0, 15)), 0, "rupd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
